// File: rtl/bus_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_mon_pkg : shared halt-cause codes and monitor state encoding      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package bus_mon_pkg;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_STOP    = 2'b01;
  localparam logic [1:0] HALT_TIMEOUT = 2'b10;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mon_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : async-reset first-word-fall-through FIFO with exact level |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/bus_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_trace_monitor : traces MMIO-window stores, counts run cycles and  |
// | halts on a stop-address access or a cycle timeout                     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bus_trace_monitor
  import bus_mon_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] WIN_BASE  = 'h800,
  parameter logic [ADDR_W-1:0] WIN_MASK  = 'h800,
  parameter logic [ADDR_W-1:0] STOP_ADDR = 'hFFC,
  parameter int                TIMEOUT   = 4000,
  parameter int                DEPTH     = 8,
  parameter int                CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      data_out,
  input  logic                   we,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [ADDR_W-1:0]      trace_addr,
  output logic [DATA_W-1:0]      trace_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic                   halt,
  output logic [1:0]             halt_cause
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mon_state_e       state_q;
  logic             halt_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  logic             running;
  logic             hit;
  logic             stop;
  logic             timeout;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ADDR_W+DATA_W-1:0] head;

  assign running = (state_q == RUN);
  assign hit     = running & we & ((address & WIN_MASK) == WIN_BASE);
  assign stop    = (address == STOP_ADDR);
  assign timeout = TO_EN & (cycle_cnt_q == TO_LAST);
  assign pop     = ~fifo_empty & trace_ready;
  assign push    = hit & (~fifo_full | pop);
  assign drop    = hit & fifo_full & ~pop;

  always_comb begin
    cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    drop_cnt_d  = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // HALTED is absorbing; only the asynchronous reset brings the monitor back to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      cause_q     <= HALT_NONE;
      cycle_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          drop_cnt_q  <= drop_cnt_d;
          if (stop || timeout) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
            cause_q <= stop ? HALT_STOP : HALT_TIMEOUT;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= HALTED;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({address, data_out}),
    .pop_i   (trace_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign trace_valid = ~fifo_empty;
  assign trace_addr  = head[ADDR_W+DATA_W-1:DATA_W];
  assign trace_data  = head[DATA_W-1:0];
  assign drop_cnt    = drop_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign halt        = halt_q;
  assign halt_cause  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_trace_monitor : directed and randomized self-checking bench    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_bus_trace_monitor;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 4;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_out = '0;
  logic        we = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [2:0]  fifo_level;
  logic [31:0] drop_cnt;
  logic [31:0] cycle_cnt;
  logic        halt;
  logic [1:0]  halt_cause;

  int n_chk  = 0;
  int n_fail = 0;

  bus_trace_monitor #(
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .data_out    (data_out),
    .we          (we),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt),
    .cycle_cnt   (cycle_cnt),
    .halt        (halt),
    .halt_cause  (halt_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: trace kept as a queue of {address,data}, counters as plain integers.
  logic [63:0]     m_q[$];
  longint unsigned m_cycles;
  longint unsigned m_drops;
  bit              m_halted;
  logic [1:0]      m_cause;
  bit              m_to;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_cycles = 0;
      m_drops  = 0;
      m_halted = 0;
      m_cause  = 2'd0;
    end else begin
      if (m_q.size() != 0 && trace_ready) void'(m_q.pop_front());
      if (!m_halted) begin
        m_to = (m_cycles == longint'(TIMEOUT - 1));
        if (m_cycles < CNT_MAX) m_cycles++;
        if (we && ((address & 32'h800) == 32'h800)) begin
          if (m_q.size() < DEPTH) m_q.push_back({address, data_out});
          else if (m_drops < CNT_MAX) m_drops++;
        end
        if (address == 32'hFFC) begin
          m_halted = 1;
          m_cause  = 2'd1;
        end else if (m_to) begin
          m_halted = 1;
          m_cause  = 2'd2;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'd0;
    chk("trace_valid", {63'd0, trace_valid}, {63'd0, m_q.size() != 0});
    chk("trace_addr", {32'd0, trace_addr}, {32'd0, head[63:32]});
    chk("trace_data", {32'd0, trace_data}, {32'd0, head[31:0]});
    chk("fifo_level", {61'd0, fifo_level}, 64'(m_q.size()));
    chk("drop_cnt", {32'd0, drop_cnt}, m_drops);
    chk("cycle_cnt", {32'd0, cycle_cnt}, m_cycles);
    chk("halt", {63'd0, halt}, {63'd0, m_halted});
    chk("halt_cause", {62'd0, halt_cause}, {62'd0, m_cause});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    // Reset held with a live window store: nothing may be captured.
    reset = 1'b1; we = 1'b1; address = 32'h800; data_out = 32'h1234;
    repeat (5) tick();
    chk("rst_valid", {63'd0, trace_valid}, 64'd0);
    chk("rst_level", {61'd0, fifo_level}, 64'd0);
    chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    reset = 1'b0; we = 1'b0; address = '0;

    we = 1'b1; address = 32'h800; data_out = 32'hDEADBEEF; trace_ready = 1'b1;
    tick();
    we = 1'b0;
    chk("st_valid", {63'd0, trace_valid}, 64'd1);
    chk("st_addr", {32'd0, trace_addr}, 64'h800);
    chk("st_data", {32'd0, trace_data}, 64'hDEADBEEF);
    tick();
    chk("st_drained", {61'd0, fifo_level}, 64'd0);
    chk("st_cycle", {32'd0, cycle_cnt}, 64'd2);

    we = 1'b1; address = 32'h400; data_out = 32'h1;
    tick();
    we = 1'b0;
    chk("out_valid", {63'd0, trace_valid}, 64'd0);
    chk("out_drop", {32'd0, drop_cnt}, 64'd0);

    reset_pulse();
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      we = 1'b1; address = 32'h800 + 32'(4 * i); data_out = 32'(i);
      tick();
    end
    we = 1'b0; address = '0;
    chk("ovf_level", {61'd0, fifo_level}, 64'd4);
    chk("ovf_drop", {32'd0, drop_cnt}, 64'd2);
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", {32'd0, trace_addr}, 64'h800 + 64'(4 * i));
      tick();
    end
    chk("ovf_empty", {61'd0, fifo_level}, 64'd0);

    address = 32'hFFC;
    tick();
    chk("stop_halt", {63'd0, halt}, 64'd1);
    chk("stop_cause", {62'd0, halt_cause}, 64'd1);
    chk("stop_cycle", {32'd0, cycle_cnt}, 64'd11);
    we = 1'b1; address = 32'h800; data_out = 32'h77;
    tick();
    we = 1'b0; address = '0;
    chk("halted_nocap", {61'd0, fifo_level}, 64'd0);
    chk("halted_frozen", {32'd0, cycle_cnt}, 64'd11);

    reset_pulse();
    repeat (15) tick();
    chk("to_pre_halt", {63'd0, halt}, 64'd0);
    tick();
    chk("to_halt", {63'd0, halt}, 64'd1);
    chk("to_cause", {62'd0, halt_cause}, 64'd2);
    chk("to_cycle", {32'd0, cycle_cnt}, 64'd16);

    reset_pulse();
    repeat (15) tick();
    address = 32'hFFC;
    tick();
    address = '0;
    chk("both_cause", {62'd0, halt_cause}, 64'd1);
    chk("both_cycle", {32'd0, cycle_cnt}, 64'd16);

    reset_pulse();
    trace_ready = 1'b0;
    we = 1'b1; address = 32'hFFC; data_out = 32'h55;
    tick();
    we = 1'b0; address = '0;
    chk("stopst_halt", {63'd0, halt}, 64'd1);
    chk("stopst_addr", {32'd0, trace_addr}, 64'hFFC);
    chk("stopst_data", {32'd0, trace_data}, 64'h55);

    reset_pulse();
    we = 1'b1; address = 32'h808;
    repeat (3) tick();
    we = 1'b0; address = '0;
    reset = 1'b1;
    #1;
    chk("mid_rst_level", {61'd0, fifo_level}, 64'd0);
    chk("mid_rst_cycle", {32'd0, cycle_cnt}, 64'd0);
    chk("mid_rst_halt", {63'd0, halt}, 64'd0);
    tick();
    reset = 1'b0;

    for (int ep = 0; ep < 60; ep++) begin
      reset_pulse();
      for (int c = 0; c < 30; c++) begin
        r = int'($urandom_range(0, 39));
        if (r == 0)       address = 32'hFFC;
        else if (r <= 20) address = 32'h800 + 32'(4 * $urandom_range(0, 15));
        else if (r <= 30) address = 32'h400 + 32'(4 * $urandom_range(0, 15));
        else              address = $urandom;
        we          = 1'($urandom_range(0, 1));
        data_out    = $urandom;
        trace_ready = ($urandom_range(0, 2) == 0);
        tick();
      end
    end

    we = 1'b0; address = '0;
    reset_pulse();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
